// File: rtl/psc_lane_array_v2_pkg.sv
// Shared definitions for the parallel<->serial lane array: mode codes, FSM states
// and the word-length / beat-count helpers used when an operation is accepted.
package psc_pkg;

    localparam logic [1:0] PSC_IDLE = 2'b00;
    localparam logic [1:0] PSC_P2S  = 2'b01;
    localparam logic [1:0] PSC_S2P  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } psc_state_e;

    // A word length of 0, or one beyond the maximum, selects the maximum.
    function automatic int psc_eff_len(input int word_len, input int max_len);
        return ((word_len == 0) || (word_len > max_len)) ? max_len : word_len;
    endfunction

    function automatic int psc_beats(input int eff_len, input int bits_per_beat);
        return (eff_len + bits_per_beat - 1) / bits_per_beat;
    endfunction

endpackage

// File: rtl/psc_lane_array_v2_lane.sv
// One lane: a per-word shift register that unloads parallel words LSB-first
// (P2S) or assembles serial beats into words (S2P), plus the fill stage that
// zero- or sign-extends assembled words above the active length.
module psc_lane
    import psc_pkg::*;
#(
    parameter int WORDS           = 4,
    parameter int MAX_WORD_LENGTH = 16,
    parameter int BITS_PER_BEAT   = 2,
    parameter int LW              = 5,
    parameter int CW              = 5,
    parameter int PW              = WORDS * MAX_WORD_LENGTH,
    parameter int SER_W           = WORDS * BITS_PER_BEAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_par,
    input  logic             clear_acc,
    input  logic             shift_out,
    input  logic             capture_in,
    input  logic             commit,
    input  logic             ser_en,
    input  logic [CW-1:0]    beat_cnt,
    input  logic [LW-1:0]    eff_len,
    input  logic             sign_ext,
    input  logic [PW-1:0]    parallel_in,
    input  logic [SER_W-1:0] serial_in,
    output logic [SER_W-1:0] serial_out,
    output logic [PW-1:0]    parallel_out
);

    localparam int MAXL = MAX_WORD_LENGTH;
    localparam int BPB  = BITS_PER_BEAT;

    logic [WORDS-1:0][MAXL-1:0] sh_q, sh_d;
    logic [WORDS-1:0][MAXL-1:0] pout_q, pout_d;
    logic [WORDS-1:0]           msb;

    // Shift register: load / clear at accept, then shift out or capture one beat per cycle.
    always_comb begin
        sh_d = sh_q;
        if (load_par) begin
            sh_d = parallel_in;
        end else if (clear_acc) begin
            sh_d = '0;
        end else if (shift_out) begin
            for (int w = 0; w < WORDS; w++) begin
                sh_d[w] = sh_q[w] >> BPB;
            end
        end else if (capture_in) begin
            for (int w = 0; w < WORDS; w++) begin
                for (int b = 0; b < MAXL; b++) begin
                    if (int'(beat_cnt) == (b / BPB)) begin
                        sh_d[w][b] = serial_in[BPB*w + (b % BPB)];
                    end
                end
            end
        end
    end

    // Top active bit of each word as it will stand after this cycle's capture.
    always_comb begin
        msb = '0;
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < MAXL; b++) begin
                if (b == int'(eff_len) - 1) begin
                    msb[w] = sh_d[w][b];
                end
            end
        end
    end

    // Parallel output: written on the last capture beat so it is valid together with finish.
    always_comb begin
        pout_d = pout_q;
        if (commit) begin
            for (int w = 0; w < WORDS; w++) begin
                for (int b = 0; b < MAXL; b++) begin
                    pout_d[w][b] = (b < int'(eff_len)) ? sh_d[w][b] : (sign_ext & msb[w]);
                end
            end
        end
    end

    // Serial output: low bits of each word, zeroed past the active length and when idle.
    always_comb begin
        serial_out = '0;
        if (ser_en) begin
            for (int w = 0; w < WORDS; w++) begin
                for (int j = 0; j < BPB; j++) begin
                    if ((int'(beat_cnt) * BPB + j) < int'(eff_len)) begin
                        serial_out[BPB*w + j] = sh_q[w][j];
                    end
                end
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            pout_q <= '0;
        end else begin
            sh_q   <= sh_d;
            pout_q <= pout_d;
        end
    end

    assign parallel_out = pout_q;

endmodule

// File: rtl/psc_lane_array_v2.sv
// Parallel<->serial converter array: one shared IDLE/SHIFT/DONE controller and
// beat counter driving NUM_LANES identical lanes.
module psc_lane_array_v2
    import psc_pkg::*;
#(
    parameter int NUM_LANES       = 2,
    parameter int WORDS           = 4,
    parameter int MAX_WORD_LENGTH = 16,
    parameter int BITS_PER_BEAT   = 2,
    localparam int LW             = $clog2(MAX_WORD_LENGTH + 1),
    localparam int PW             = WORDS * MAX_WORD_LENGTH,
    localparam int SER_W          = WORDS * BITS_PER_BEAT,
    localparam int CW             = $clog2(MAX_WORD_LENGTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic                       start,
    input  logic [LW-1:0]              word_len,
    input  logic                       sign_ext,
    input  logic [NUM_LANES-1:0]       lane_mask,
    output logic                       busy,
    output logic                       finish,
    output logic                       ser_out_valid,
    output logic                       ser_in_ready,
    input  logic [NUM_LANES*SER_W-1:0] serial_data_in,
    input  logic [NUM_LANES*PW-1:0]    parallel_data_in,
    output logic [NUM_LANES*SER_W-1:0] serial_data_out,
    output logic [NUM_LANES*PW-1:0]    parallel_data_out
);

    psc_state_e           state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 sext_q, sext_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [CW-1:0]        beats_q, beats_d;
    logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
    logic                 accept, last_beat, in_shift, is_p2s, is_s2p;
    int                   eff_in;

    assign eff_in    = psc_eff_len(int'(word_len), MAX_WORD_LENGTH);
    assign last_beat = (beat_cnt_q == beats_q - CW'(1));
    assign in_shift  = (state_q == ST_SHIFT);
    assign is_p2s    = (mode_q == PSC_P2S);
    assign is_s2p    = (mode_q == PSC_S2P);

    // Next-state logic; operation parameters are captured only on accept.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        sext_d     = sext_q;
        mask_d     = mask_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && ((mode == PSC_P2S) || (mode == PSC_S2P))) begin
                    accept     = 1'b1;
                    state_d    = ST_SHIFT;
                    mode_d     = mode;
                    len_d      = LW'(eff_in);
                    beats_d    = CW'(psc_beats(eff_in, BITS_PER_BEAT));
                    sext_d     = sign_ext;
                    mask_d     = lane_mask;
                    beat_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end else begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= PSC_IDLE;
            len_q      <= '0;
            sext_q     <= 1'b0;
            mask_q     <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            sext_q     <= sext_d;
            mask_q     <= mask_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign finish        = (state_q == ST_DONE);
    assign ser_out_valid = in_shift & is_p2s;
    assign ser_in_ready  = in_shift & is_s2p;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        psc_lane #(
            .WORDS           (WORDS),
            .MAX_WORD_LENGTH (MAX_WORD_LENGTH),
            .BITS_PER_BEAT   (BITS_PER_BEAT),
            .LW              (LW),
            .CW              (CW),
            .PW              (PW),
            .SER_W           (SER_W)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .load_par     (accept && (mode == PSC_P2S)),
            .clear_acc    (accept && (mode == PSC_S2P)),
            .shift_out    (ser_out_valid),
            .capture_in   (ser_in_ready & mask_q[i]),
            .commit       (ser_in_ready & mask_q[i] & last_beat),
            .ser_en       (ser_out_valid & mask_q[i]),
            .beat_cnt     (beat_cnt_q),
            .eff_len      (len_q),
            .sign_ext     (sext_q),
            .parallel_in  (parallel_data_in[PW*i +: PW]),
            .serial_in    (serial_data_in[SER_W*i +: SER_W]),
            .serial_out   (serial_data_out[SER_W*i +: SER_W]),
            .parallel_out (parallel_data_out[PW*i +: PW])
        );
    end

endmodule

// File: tb/tb_psc_lane_array_v2.sv
// Directed bench for psc_lane_array_v2 (2 lanes, 4 words, 16-bit max, 2 bits/beat).
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_psc_lane_array_v2;

    localparam int NL    = 2;
    localparam int WORDS = 4;
    localparam int BPB   = 2;
    localparam int SER_W = 8;
    localparam int PW    = 64;
    localparam int LW    = 5;

    localparam logic [1:0] M_P2S = 2'b01;
    localparam logic [1:0] M_S2P = 2'b10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           mode;
    logic                 start;
    logic [LW-1:0]        word_len;
    logic                 sign_ext;
    logic [NL-1:0]        lane_mask;
    logic                 busy, finish, ser_out_valid, ser_in_ready;
    logic [NL*SER_W-1:0]  serial_data_in, serial_data_out;
    logic [NL*PW-1:0]     parallel_data_in, parallel_data_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0]      pw  [NL][WORDS];
    logic [7:0]       sin [NL][8];
    logic [7:0]       first_ser0;
    logic [NL*PW-1:0] pout_fin;

    always #5 clk = ~clk;

    psc_lane_array_v2 dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .start             (start),
        .word_len          (word_len),
        .sign_ext          (sign_ext),
        .lane_mask         (lane_mask),
        .busy              (busy),
        .finish            (finish),
        .ser_out_valid     (ser_out_valid),
        .ser_in_ready      (ser_in_ready),
        .serial_data_in    (serial_data_in),
        .parallel_data_in  (parallel_data_in),
        .serial_data_out   (serial_data_out),
        .parallel_data_out (parallel_data_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NL*PW-1:0] pack_par();
        logic [NL*PW-1:0] v;
        v = '0;
        for (int l = 0; l < NL; l++)
            for (int w = 0; w < WORDS; w++)
                v[PW*l + 16*w +: 16] = pw[l][w];
        return v;
    endfunction

    // Expected serial beat of one lane: bit j of word w carries word bit k*BPB+j if below eff.
    function automatic logic [7:0] exp_ser(input int l, input int k, input int eff, input logic en);
        logic [7:0] v;
        v = '0;
        if (en)
            for (int w = 0; w < WORDS; w++)
                for (int j = 0; j < BPB; j++)
                    if (k*BPB + j < eff)
                        v = v | (8'(pw[l][w] >> (k*BPB + j)) & 8'h01) << (BPB*w + j);
        return v;
    endfunction

    // One complete operation starting in the current (idle) cycle; returns in cycle beats+2,
    // which is the earliest cycle a following start may be accepted.
    task automatic run_op(input logic [1:0] m, input logic [4:0] wl, input int eff,
                          input logic se, input logic [1:0] msk, input int beats,
                          input logic poke);
        logic [NL*PW-1:0] pin;
        pin = pack_par();
        `CHK("idle_before_start", busy, 1'b0);
        mode = m; word_len = wl; sign_ext = se; lane_mask = msk;
        parallel_data_in = pin; start = 1'b1;
        step();
        mode = 2'b00; word_len = 5'd1; sign_ext = ~se; lane_mask = ~msk;
        parallel_data_in = ~pin; start = 1'b0;
        for (int k = 0; k < beats; k++) begin
            serial_data_in = {sin[1][k], sin[0][k]};
            start = poke && (k == 2);
            mode  = (poke && (k == 2)) ? M_S2P : 2'b00;
            `CHK("busy_in_shift", busy, 1'b1);
            `CHK("finish_in_shift", finish, 1'b0);
            `CHK("ser_out_valid", ser_out_valid, m == M_P2S);
            `CHK("ser_in_ready", ser_in_ready, m == M_S2P);
            `CHK("serial_lane0", serial_data_out[7:0], exp_ser(0, k, eff, msk[0] && (m == M_P2S)));
            `CHK("serial_lane1", serial_data_out[15:8], exp_ser(1, k, eff, msk[1] && (m == M_P2S)));
            if (k == 0) first_ser0 = serial_data_out[7:0];
            step();
        end
        serial_data_in = '1; start = 1'b0; mode = 2'b00;
        `CHK("finish_pulse", finish, 1'b1);
        `CHK("busy_in_done", busy, 1'b1);
        `CHK("valid_in_done", ser_out_valid, 1'b0);
        `CHK("ready_in_done", ser_in_ready, 1'b0);
        `CHK("serial_zero_done", serial_data_out, 16'h0000);
        pout_fin = parallel_data_out;
        step();
        `CHK("finish_cleared", finish, 1'b0);
        `CHK("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; start = 1'b0; word_len = '0; sign_ext = 1'b0;
        lane_mask = '0; serial_data_in = '1; parallel_data_in = '1;
        pw[0] = '{16'h0001, 16'h8000, 16'hFFFF, 16'hA5A5};
        pw[1] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        for (int l = 0; l < NL; l++) for (int k = 0; k < 8; k++) sin[l][k] = 8'hFF;
        step();
        step();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $error("FAIL rst_busy: %b", busy); end
        vectors++;
        if (finish !== 1'b0) begin miscompares++; $error("FAIL rst_finish: %b", finish); end
        vectors++;
        if (ser_out_valid !== 1'b0) begin miscompares++; $error("FAIL rst_valid: %b", ser_out_valid); end
        vectors++;
        if (ser_in_ready !== 1'b0) begin miscompares++; $error("FAIL rst_ready: %b", ser_in_ready); end
        vectors++;
        if (serial_data_out !== 16'h0000) begin miscompares++; $error("FAIL rst_serial: %h", serial_data_out); end
        vectors++;
        if (parallel_data_out[63:0] !== 64'h0) begin miscompares++; $error("FAIL rst_par_lane0: %h", parallel_data_out[63:0]); end
        vectors++;
        if (parallel_data_out[127:64] !== 64'h0) begin miscompares++; $error("FAIL rst_par_lane1: %h", parallel_data_out[127:64]); end
        reset = 1'b0;
        step();

        // P2S, full length, both lanes; a start poked mid-operation must be ignored.
        run_op(M_P2S, 5'd16, 16, 1'b0, 2'b11, 8, 1'b1);
        `CHK("p2s_beat0_lane0", first_ser0, 8'b01_11_00_01);

        // S2P, length 5, sign-extended (back-to-back with the previous operation).
        sin[0][0] = 8'h03; sin[0][1] = 8'h01; sin[0][2] = 8'h03;
        sin[1][0] = 8'hFF; sin[1][1] = 8'h00; sin[1][2] = 8'hFF;
        run_op(M_S2P, 5'd5, 5, 1'b1, 2'b11, 3, 1'b0);
        `CHK("s2p_sext_lane0", pout_fin[63:0], 64'h0000_0000_0000_FFF7);
        `CHK("s2p_sext_lane1", pout_fin[127:64], 64'hFFF3_FFF3_FFF3_FFF3);

        // Same data zero-filled.
        run_op(M_S2P, 5'd5, 5, 1'b0, 2'b11, 3, 1'b0);
        `CHK("s2p_zero_lane0", pout_fin[63:0], 64'h0000_0000_0000_0017);
        `CHK("s2p_zero_lane1", pout_fin[127:64], 64'h0013_0013_0013_0013);
        `CHK("par_holds_idle", parallel_data_out[127:64], 64'h0013_0013_0013_0013);

        // Lane 1 masked: P2S length 8 keeps its serial output at zero.
        run_op(M_P2S, 5'd8, 8, 1'b0, 2'b01, 4, 1'b0);

        // Lane 1 masked: S2P leaves its parallel output untouched.
        for (int k = 0; k < 3; k++) begin sin[0][k] = 8'h00; sin[1][k] = 8'hFF; end
        run_op(M_S2P, 5'd5, 5, 1'b1, 2'b01, 3, 1'b0);
        `CHK("mask_s2p_lane0", pout_fin[63:0], 64'h0);
        `CHK("mask_s2p_lane1", pout_fin[127:64], 64'h0013_0013_0013_0013);

        // word_len 0 means maximum length.
        run_op(M_P2S, 5'd0, 16, 1'b0, 2'b11, 8, 1'b0);

        // word_len 1: a single beat, upper bit of each word's pair forced to zero.
        pw[0][0] = 16'h0003;
        run_op(M_P2S, 5'd1, 1, 1'b0, 2'b11, 1, 1'b0);
        `CHK("len1_beat0_lane0", first_ser0, 8'h51);

        // Reserved mode and idle mode starts are ignored.
        mode = 2'b11; start = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $error("FAIL mode11_ignored: %b", busy); end
        mode = 2'b00;
        step();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $error("FAIL mode00_ignored: %b", busy); end
        vectors++;
        if (finish !== 1'b0) begin miscompares++; $error("FAIL no_finish_ignored: %b", finish); end
        step();

        // Reset during the third SHIFT beat.
        mode = M_S2P; word_len = 5'd16; lane_mask = 2'b11; sign_ext = 1'b0; start = 1'b1;
        step();
        start = 1'b0; mode = 2'b00;
        step();
        step();
        `CHK("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        `CHK("mid_rst_busy", busy, 1'b0);
        `CHK("mid_rst_ready", ser_in_ready, 1'b0);
        `CHK("mid_rst_par_lane1", parallel_data_out[127:64], 64'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (finish !== 1'b0) begin miscompares++; $error("FAIL post_rst_no_finish at %0d", i); end
            step();
        end

        // Full S2P after reset, word_len above maximum selects the maximum.
        for (int k = 0; k < 8; k++) begin sin[0][k] = 8'hE4; sin[1][k] = 8'h1B; end
        run_op(M_S2P, 5'd20, 16, 1'b0, 2'b11, 8, 1'b0);
        `CHK("s2p_full_lane0", pout_fin[63:0], 64'hFFFF_AAAA_5555_0000);
        `CHK("s2p_full_lane1", pout_fin[127:64], 64'h0000_5555_AAAA_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
